// File: rtl/lfsr_addr_sequencer.sv
// Issues runs of pseudo-random 4-bit addresses from a 16-state de Bruijn LFSR over valid/ready.
// Reports busy, done and cycle-wrap to the memory-control FSM.
module lfsr_addr_sequencer #(
  parameter logic [3:0] SEED    = 4'b0001,
  parameter int         MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] len_in,
  input  logic       load_seed,
  input  logic [3:0] seed_in,
  input  logic       abort,
  output logic [3:0] addr,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

  state_t     state, state_nx;
  logic [3:0] lfsr, lfsr_nx, lfsr_step;
  logic [4:0] remaining, remaining_nx, eff_len;
  logic       wrap_r, wrap_nx;
  logic       accept;

  // The (s[2:0]==0) term splices 0000 into the maximal-length sequence.
  assign lfsr_step = {lfsr[2:0], lfsr[3] ^ lfsr[2] ^ (lfsr[2:0] == 3'b000)};
  assign accept    = (state == RUN) && ready;

  always_comb begin
    eff_len = len_in;
    if (len_in == 5'd0) begin
      eff_len = MAX_LEN_L;
    end else if (len_in > 5'd16) begin
      eff_len = 5'd16;
    end
  end

  always_comb begin
    state_nx     = state;
    lfsr_nx      = lfsr;
    remaining_nx = remaining;
    wrap_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (load_seed) begin
          lfsr_nx = seed_in;
        end
        if (start) begin
          remaining_nx = eff_len;
          state_nx     = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          lfsr_nx      = lfsr_step;
          remaining_nx = remaining - 5'd1;
          wrap_nx      = (lfsr == 4'b0000);
          if (remaining == 5'd1) begin
            state_nx = DONE;
          end
        end
        // Abort overrides completion; the LFSR keeps any step taken this cycle.
        if (abort) begin
          state_nx     = IDLE;
          remaining_nx = 5'd0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      remaining <= 5'd0;
      wrap_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      remaining <= remaining_nx;
      wrap_r    <= wrap_nx;
    end
  end

  assign addr  = lfsr;
  assign valid = (state == RUN);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_lfsr_addr_sequencer.sv
// Directed bench for lfsr_addr_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_lfsr_addr_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] len_in;
  logic       load_seed;
  logic [3:0] seed_in;
  logic       abort;
  logic [3:0] addr;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  // Hand-derived code order starting from 0001.
  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

  lfsr_addr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_in    (len_in),
    .load_seed (load_seed),
    .seed_in   (seed_in),
    .abort     (abort),
    .addr      (addr),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (addr !== 4'h1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: addr=%h valid=%b busy=%b done=%b wrap=%b required addr=1 all flags 0",
               addr, valid, busy, done, wrap);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_cycle();
    logic exp_w;
    len_in = 5'd16; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_w = 1'b0;
      if (i > 0) exp_w = (seq[i-1] == 4'h0);
      checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || addr !== seq[i] || done !== 1'b0 || wrap !== exp_w) begin
        errors++;
        $display("FAIL full_cycle[%0d]: addr=%h valid=%b busy=%b done=%b wrap=%b required addr=%h 1 1 0 %b",
                 i, addr, valid, busy, done, wrap, seq[i], exp_w);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL full_cycle_done: done=%b valid=%b busy=%b wrap=%b required 1 0 0 1",
               done, valid, busy, wrap);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || wrap !== 1'b0 || valid !== 1'b0 || addr !== 4'h1) begin
      errors++;
      $display("FAIL full_cycle_idle: done=%b wrap=%b valid=%b addr=%h required 0 0 0 1",
               done, wrap, valid, addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      len_in = 5'd3; start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (valid !== 1'b1 || addr !== seq[3*r+i] || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_run%0d[%0d]: addr=%h valid=%b done=%b required addr=%h valid=1 done=0",
                   r, i, addr, valid, done, seq[3*r+i]);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done%0d: done=%b valid=%b required 1 0", r, done, valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_single_pulse%0d: done=%b required 0", r, done);
      end
    end
  endtask

  task automatic test_seed_load();
    len_in = 5'd4; start = 1'b1; load_seed = 1'b1; seed_in = 4'hB; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; load_seed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || addr !== seq[9+i]) begin
        errors++;
        $display("FAIL seed_load[%0d]: addr=%h valid=%b required addr=%h valid=1",
                 i, addr, valid, seq[9+i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL seed_load_done: done=%b required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [6:0] pat = 7'b1011001;  // ready per cycle, bit 0 first: 1,0,0,1,1,0,1
    int         acc = 0;
    logic       prev_zero = 1'b0;
    logic [3:0] exp_a;
    len_in = 5'd4; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_a = seq[(13 + acc) % 16];
      checks++;
      if (valid !== 1'b1 || addr !== exp_a || wrap !== prev_zero || done !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: addr=%h valid=%b wrap=%b done=%b required addr=%h valid=1 wrap=%b done=0",
                 i, addr, valid, wrap, done, exp_a, prev_zero);
      end
      ready = pat[i];
      // start/load_seed during RUN must be ignored
      load_seed = (i == 1); start = (i == 1); seed_in = 4'h5;
      prev_zero = pat[i] && (exp_a == 4'h0);
      if (pat[i]) acc++;
      @(negedge clk);
    end
    load_seed = 1'b0; start = 1'b0;
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || wrap !== prev_zero) begin
      errors++;
      $display("FAIL stall_done: done=%b valid=%b wrap=%b required 1 0 %b", done, valid, wrap, prev_zero);
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || addr !== 4'h2) begin
      errors++;
      $display("FAIL stall_after: done=%b addr=%h required 0 2", done, addr);
    end
  endtask

  task automatic test_abort();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    len_in = 5'd8; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid !== 1'b1 || addr !== seq[i]) begin
        errors++;
        $display("FAIL abort_pre[%0d]: addr=%h valid=%b required addr=%h valid=1", i, addr, valid, seq[i]);
      end
      if (i == 2) begin
        abort = 1'b1; ready = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr !== 4'h4) begin
      errors++;
      $display("FAIL abort_stop: valid=%b busy=%b done=%b addr=%h required 0 0 0 4", valid, busy, done, addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b valid=%b required 0 0", done, valid);
    end
    len_in = 5'd2; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || addr !== 4'h4) begin
      errors++;
      $display("FAIL abort_resume: addr=%h valid=%b required 4 1", addr, valid);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || addr !== 4'h9) begin
      errors++;
      $display("FAIL abort_resume2: addr=%h valid=%b required 9 1", addr, valid);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || addr !== 4'h3) begin
      errors++;
      $display("FAIL abort_with_accept: valid=%b done=%b addr=%h required 0 0 3", valid, done, addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_accept_done: done=%b required 0", done);
    end
  endtask

  task automatic test_len_limits();
    logic [4:0] lens [2] = '{5'd0, 5'd31};
    logic       exp_w;
    for (int r = 0; r < 2; r++) begin
      len_in = lens[r]; start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
        exp_w = 1'b0;
        if (i > 0) exp_w = (seq[(4 + i - 1) % 16] == 4'h0);
        checks++;
        if (valid !== 1'b1 || addr !== seq[(4 + i) % 16] || wrap !== exp_w || done !== 1'b0) begin
          errors++;
          $display("FAIL len_%0d[%0d]: addr=%h valid=%b wrap=%b done=%b required addr=%h valid=1 wrap=%b done=0",
                   lens[r], i, addr, valid, wrap, done, seq[(4 + i) % 16], exp_w);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL len_%0d_done: done=%b valid=%b required 1 0", lens[r], done, valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    len_in = 5'd8; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_running: valid=%b busy=%b required 1 1", valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (addr !== 4'h1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: addr=%h valid=%b busy=%b done=%b wrap=%b required 1 0 0 0 0",
               addr, valid, busy, done, wrap);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after: done=%b valid=%b required 0 0", done, valid);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len_in = 5'd0; load_seed = 1'b0;
    seed_in = 4'h0; abort = 1'b0; ready = 1'b0;
    test_reset();
    test_full_cycle();
    test_back_to_back();
    test_seed_load();
    test_stall();
    test_abort();
    test_len_limits();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
